// File: rtl/router_pkg.sv
// Constants and header helpers shared by router_fifo, router_sync and router_fsm.
package router_pkg;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// 1W1R register array with no reset; the read port is combinational so the parent
// can register the byte and decode its tag on the same edge.
module router_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores {header tag, byte} entries and
// tracks the remaining byte count of the packet currently being read out.
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_active
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [6:0]      pkt_cnt;
    logic [DATA_W:0] rd_entry;
    logic            wr_ok;
    logic            rd_ok;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign pkt_active = (pkt_cnt != 7'd0);

    // Both strobes are qualified by pre-edge status, so a full FIFO drops the write
    // and an empty FIFO ignores the read even when the other side is active.
    assign wr_ok = write_enb && !full && !soft_reset;
    assign rd_ok = read_enb && !empty;

    router_fifo_mem #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({lfd_state, data_in}),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_entry[DATA_W-1:0];
                // Header reload counts the payload plus the trailing parity byte.
                if (rd_entry[DATA_W]) begin
                    pkt_cnt <= 7'({1'b0, hdr_len(rd_entry[DATA_W-1:0])}) + 7'd1;
                end else if (pkt_cnt != 7'd0) begin
                    pkt_cnt <= pkt_cnt - 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based reference model plus directed
// and randomized stimulus.
module tb_router_fifo;

    localparam int DP = 16;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_active;

    always #5 clock = ~clock;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_active (pkt_active)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    logic [8:0] q[$];
    logic [7:0] m_dout;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_empty",      32'(empty),      32'(q.size() == 0));
            check("model_full",       32'(full),       32'(q.size() == DP));
            check("model_data_out",   32'(data_out),   32'(m_dout));
            check("model_pkt_active", 32'(pkt_active), 32'(m_cnt != 0));
        end
    end

    // Drives one cycle of stimulus and advances the model by the same edge.
    task automatic step(input bit we, input bit lfd, input logic [7:0] din,
                        input bit re, input bit sr);
        logic [8:0] e;
        bit rd;
        bit wr;
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        rd = re && (q.size() != 0);
        wr = we && (q.size() != DP);
        @(posedge clock);
        #1;
        if (sr) begin
            q.delete();
            m_dout = 8'h00;
            m_cnt  = 0;
        end else begin
            if (rd) begin
                e = q.pop_front();
                m_dout = e[7:0];
                if (e[8]) m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt--;
            end
            if (wr) q.push_back({lfd, din});
        end
    endtask

    task automatic idle_inputs();
        write_enb = 0; lfd_state = 0; data_in = 0; read_enb = 0; soft_reset = 0;
    endtask

    initial begin
        logic [7:0] pkt[5];
        logic [7:0] fb[16];
        logic [7:0] prev;
        int n;

        pkt = '{8'h0E, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
        resetn = 1'b0;
        idle_inputs();
        m_dout = 8'h00;
        m_cnt  = 0;

        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_dout",  32'(data_out), 32'h00);
        check("rst_pkt",   32'(pkt_active), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        check("idle_read_dout", 32'(data_out), 32'h00);
        check("idle_read_empty", 32'(empty), 32'd1);

        // Header 0E: length 3, so 3 payload bytes plus parity follow.
        for (int i = 0; i < 5; i++) step(1, (i == 0), pkt[i], 0, 0);
        check("pkt_not_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1, 0);
            check("pkt_data",   32'(data_out),   32'(pkt[i]));
            check("pkt_active", 32'(pkt_active), 32'(i < 4));
        end
        check("pkt_drained", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) begin
            fb[i] = 8'($urandom_range(0, 254));
            step(1, 0, fb[i], 0, 0);
        end
        check("fill_full", 32'(full), 32'd1);
        step(1, 0, 8'hFF, 0, 0);
        check("overflow_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1, 0);
            check("fill_data", 32'(data_out), 32'(fb[i]));
        end
        check("fill_drained", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) begin
            fb[i] = 8'($urandom_range(0, 254));
            step(1, 0, fb[i], 0, 0);
        end
        step(1, 0, 8'h77, 1, 0);
        check("simul_full_clear", 32'(full), 32'd0);
        check("simul_full_data",  32'(data_out), 32'(fb[0]));
        n = 0;
        while (!empty && n < 40) begin
            step(0, 0, 8'h00, 1, 0);
            n++;
        end
        check("simul_remaining", 32'(n), 32'd15);
        check("simul_last_data", 32'(data_out), 32'(fb[15]));

        prev = data_out;
        step(1, 0, 8'h33, 1, 0);
        check("simul_empty_hold", 32'(data_out), 32'(prev));
        check("simul_empty_wrote", 32'(empty), 32'd0);
        step(0, 0, 8'h00, 1, 0);
        check("simul_empty_data", 32'(data_out), 32'h33);
        check("simul_empty_drain", 32'(empty), 32'd1);

        // Streaming traffic at occupancy one walks the pointers across the wrap twice.
        for (int i = 0; i < 40; i++) step(1, 0, 8'(8'h40 + i), (i > 0), 0);
        step(0, 0, 8'h00, 1, 0);
        check("wrap_data", 32'(data_out), 32'h67);

        repeat (400) begin
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0), 8'($urandom),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 199) == 0));
        end
        step(0, 0, 8'h00, 0, 1);

        step(1, 1, 8'h14, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("sr_pre_dout", 32'(data_out), 32'h14);
        check("sr_pre_pkt",  32'(pkt_active), 32'd1);
        step(1, 0, 8'h99, 0, 1);
        check("sr_empty", 32'(empty), 32'd1);
        check("sr_full",  32'(full),  32'd0);
        check("sr_dout",  32'(data_out), 32'h00);
        check("sr_pkt",   32'(pkt_active), 32'd0);
        step(0, 0, 8'h00, 1, 0);
        check("sr_nothing_stored", 32'(empty), 32'd1);
        check("sr_read_hold", 32'(data_out), 32'h00);

        step(1, 1, 8'h08, 0, 0);
        step(1, 0, 8'hD1, 0, 0);
        step(1, 0, 8'hD2, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("ar_pre_dout", 32'(data_out), 32'h08);
        idle_inputs();
        #2;
        resetn = 1'b0;
        q.delete();
        m_dout = 8'h00;
        m_cnt  = 0;
        #1;
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_full",  32'(full),  32'd0);
        check("ar_dout",  32'(data_out), 32'h00);
        check("ar_pkt",   32'(pkt_active), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        step(0, 0, 8'h00, 1, 0);
        check("ar_contents_lost", 32'(empty), 32'd1);
        check("ar_read_hold", 32'(data_out), 32'h00);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
